// File: rtl/async_fifo_gray.sv
// async_fifo_gray: dual-clock FIFO with Gray-coded pointer crossing.
//
// Ports
//   w_clk, r_clk        write / read clocks (mutually asynchronous)
//   rst                 synchronous active-high reset, sampled in both domains
//   w_en, data_in       write request and data (w_clk domain)
//   r_en, data_out      read request and registered read data (r_clk domain)
//   full, almost_full   write-side status, registered on w_clk
//   empty, almost_empty read-side status, registered on r_clk
//   wr_count, rd_count  occupancy as seen from each domain (0..DEPTH)
//   overflow, underflow sticky error flags
//
// Build option
//   FIFO_ERR_FLAGS_EN   when defined, overflow/underflow are live sticky
//                       flags; otherwise both are tied to 0.
//
// Parameters: WIDTH (data width), DEPTH (power of two, 4..256),
//   AF_LEVEL (almost_full threshold), AE_LEVEL (almost_empty threshold).

module async_fifo_gray #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                       w_clk,
  input  logic                       r_clk,
  input  logic                       rst,
  input  logic                       w_en,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       r_en,
  output logic [WIDTH-1:0]           data_out,
  output logic                       full,
  output logic                       almost_full,
  output logic                       empty,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     wr_count,
  output logic [$clog2(DEPTH):0]     rd_count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [AW:0] AF_THR = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_THR = (AW+1)'(AE_LEVEL);

  function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
    logic [AW:0] b;
    b = g;
    for (int unsigned i = 1; i <= AW; i++) b = b ^ (g >> i);
    return b;
  endfunction

  logic [WIDTH-1:0] mem [DEPTH];

  // ---------------- write domain ----------------
  logic [AW:0] wbin, wgray, rq1, rq2;
  logic [AW:0] wbin_next, wgray_next, wr_count_next;
  logic        w_acc, full_next, almost_full_next;

  always_comb begin
    w_acc            = w_en && !full && !rst;
    wbin_next        = wbin + {{AW{1'b0}}, w_acc};
    wgray_next       = bin2gray(wbin_next);
    // Full when the write pointer has lapped the synced read pointer once:
    // in Gray code that is equality with the two MSBs inverted.
    full_next        = (wgray_next == {~rq2[AW:AW-1], rq2[AW-2:0]});
    wr_count_next    = wbin_next - gray2bin(rq2);
    almost_full_next = (wr_count_next >= AF_THR);
  end

  always_ff @(posedge w_clk) begin
    if (rst) begin
      wbin        <= '0;
      wgray       <= '0;
      rq1         <= '0;
      rq2         <= '0;
      wr_count    <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      wbin        <= wbin_next;
      wgray       <= wgray_next;
      rq1         <= rgray;
      rq2         <= rq1;
      wr_count    <= wr_count_next;
      full        <= full_next;
      almost_full <= almost_full_next;
    end
  end

  always_ff @(posedge w_clk) begin
    if (w_acc) mem[wbin[AW-1:0]] <= data_in;
  end

  // ---------------- read domain ----------------
  logic [AW:0] rbin, rgray, wq1, wq2;
  logic [AW:0] rbin_next, rgray_next, rd_count_next;
  logic        r_acc, empty_next, almost_empty_next;

  always_comb begin
    r_acc             = r_en && !empty && !rst;
    rbin_next         = rbin + {{AW{1'b0}}, r_acc};
    rgray_next        = bin2gray(rbin_next);
    empty_next        = (rgray_next == wq2);
    rd_count_next     = gray2bin(wq2) - rbin_next;
    almost_empty_next = (rd_count_next <= AE_THR);
  end

  always_ff @(posedge r_clk) begin
    if (rst) begin
      rbin         <= '0;
      rgray        <= '0;
      wq1          <= '0;
      wq2          <= '0;
      rd_count     <= '0;
      data_out     <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
    end else begin
      rbin         <= rbin_next;
      rgray        <= rgray_next;
      wq1          <= wgray;
      wq2          <= wq1;
      rd_count     <= rd_count_next;
      empty        <= empty_next;
      almost_empty <= almost_empty_next;
      if (r_acc) data_out <= mem[rbin[AW-1:0]];
    end
  end

  // ---------------- error flags ----------------
`ifdef FIFO_ERR_FLAGS_EN
  always_ff @(posedge w_clk) begin
    if (rst)               overflow <= 1'b0;
    else if (w_en && full) overflow <= 1'b1;
  end

  always_ff @(posedge r_clk) begin
    if (rst)                underflow <= 1'b0;
    else if (r_en && empty) underflow <= 1'b1;
  end
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_async_fifo_gray.sv
// Directed self-checking bench for async_fifo_gray (WIDTH=8, DEPTH=16,
// w_clk 10 ns, r_clk 25 ns). Expected overflow/underflow follow whether
// FIFO_ERR_FLAGS_EN is defined for the build.
`timescale 1ns/1ps

module tb_async_fifo_gray;

`ifdef FIFO_ERR_FLAGS_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic       w_clk = 1'b0;
  logic       r_clk = 1'b0;
  logic       rst = 1'b1;
  logic       w_en = 1'b0;
  logic [7:0] data_in = '0;
  logic       r_en = 1'b0;
  logic [7:0] data_out;
  logic       full, almost_full, empty, almost_empty;
  logic [4:0] wr_count, rd_count;
  logic       overflow, underflow;

  int checks = 0;
  int errors = 0;

  async_fifo_gray #(
    .WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2)
  ) dut (
    .w_clk(w_clk), .r_clk(r_clk), .rst(rst),
    .w_en(w_en), .data_in(data_in),
    .r_en(r_en), .data_out(data_out),
    .full(full), .almost_full(almost_full),
    .empty(empty), .almost_empty(almost_empty),
    .wr_count(wr_count), .rd_count(rd_count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5    w_clk = ~w_clk;
  always #12.5 r_clk = ~r_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] d);
    w_en = 1'b1;
    data_in = d;
    @(posedge w_clk);
    #1;
    w_en = 1'b0;
  endtask

  task automatic rd();
    r_en = 1'b1;
    @(posedge r_clk);
    #1;
    r_en = 1'b0;
  endtask

  task automatic r_idle(input int n);
    repeat (n) @(posedge r_clk);
    #1;
  endtask

  task automatic w_idle(input int n);
    repeat (n) @(posedge w_clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int  n;
    int  exp_rd;
    int  cyc;
    logic e;

    // Reset and idle
    rst = 1'b1;
    r_idle(3);
    rst = 1'b0;
    r_idle(4);
    chk("rst_empty", empty, 1);
    chk("rst_almost_empty", almost_empty, 1);
    chk("rst_full", full, 0);
    chk("rst_almost_full", almost_full, 0);
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_wr_count", wr_count, 0);
    chk("rst_rd_count", rd_count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_underflow", underflow, 0);

    // Fill: 16 words 01..10
    for (int i = 1; i <= 16; i++) begin
      wr(8'(i));
      chk($sformatf("fill_full_%0d", i), full, (i == 16) ? 1 : 0);
      chk($sformatf("fill_af_%0d", i), almost_full, (i >= 14) ? 1 : 0);
      chk($sformatf("fill_wr_count_%0d", i), wr_count, i);
    end
    wr(8'hFF);
    chk("ovf_full", full, 1);
    chk("ovf_wr_count", wr_count, 16);
    chk("ovf_flag", overflow, ERR_EN);

    r_idle(4);
    chk("filled_rd_count", rd_count, 16);
    chk("filled_empty", empty, 0);
    chk("filled_almost_empty", almost_empty, 0);

    // Drain: 16 reads, 8'hFF must not appear
    for (int i = 1; i <= 16; i++) begin
      rd();
      chk($sformatf("drain_data_%0d", i), data_out, i);
      chk($sformatf("drain_empty_%0d", i), empty, (i == 16) ? 1 : 0);
      chk($sformatf("drain_rd_count_%0d", i), rd_count, 16 - i);
      chk($sformatf("drain_ae_%0d", i), almost_empty, (i >= 14) ? 1 : 0);
      if (i == 1) begin
        n = 0;
        while (full && n < 3) begin
          @(posedge w_clk);
          #1;
          n++;
        end
        chk("full_release_3_edges", full, 0);
      end
    end
    rd();
    chk("udf_data_hold", data_out, 8'h10);
    chk("udf_flag", underflow, ERR_EN);
    chk("udf_rd_count", rd_count, 0);
    w_idle(4);
    chk("drained_full", full, 0);
    chk("drained_wr_count", wr_count, 0);
    chk("drained_almost_full", almost_full, 0);

    // Continuous stream of 40 words across pointer wraps
    exp_rd = 0;
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          wr(8'(k));
          chk($sformatf("stream_full_%0d", k), full, 0);
          w_idle(2);
        end
      end
      begin
        cyc = 0;
        while (exp_rd < 40 && cyc < 200) begin
          r_en = 1'b1;
          e = empty;
          @(posedge r_clk);
          #1;
          cyc++;
          if (!e) begin
            chk($sformatf("stream_data_%0d", exp_rd), data_out, exp_rd);
            exp_rd++;
          end
        end
        r_en = 1'b0;
      end
    join
    chk("stream_word_count", exp_rd, 40);
    chk("stream_end_empty", empty, 1);
    chk("stream_end_rd_count", rd_count, 0);

    // Reset mid-operation discards stored words
    for (int k = 0; k < 5; k++) wr(8'(8'h50 + k));
    r_idle(4);
    chk("pre_rst_rd_count", rd_count, 5);
    rst = 1'b1;
    r_idle(3);
    rst = 1'b0;
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_almost_empty", almost_empty, 1);
    chk("mid_rst_full", full, 0);
    chk("mid_rst_almost_full", almost_full, 0);
    chk("mid_rst_wr_count", wr_count, 0);
    chk("mid_rst_rd_count", rd_count, 0);
    chk("mid_rst_data_out", data_out, 8'h00);
    chk("mid_rst_overflow", overflow, 0);
    chk("mid_rst_underflow", underflow, 0);
    wr(8'hA5);
    r_idle(4);
    rd();
    chk("post_rst_data", data_out, 8'hA5);
    chk("post_rst_empty", empty, 1);

    // Single write: empty must clear within 3 r_clk edges
    wr(8'h3C);
    n = 0;
    while (empty && n < 3) begin
      @(posedge r_clk);
      #1;
      n++;
    end
    chk("single_empty_release", empty, 0);
    chk("single_rd_count", rd_count, 1);
    chk("single_almost_empty", almost_empty, 1);
    rd();
    chk("single_data", data_out, 8'h3C);
    chk("single_final_empty", empty, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/async_fifo_gray.md
ASYNC_FIFO_GRAY -- requirements
Module: async_fifo_gray

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits.
REQ-002 Parameter DEPTH, default 16, entries; power of two, 4..256.
REQ-003 Parameter AF_LEVEL, default DEPTH-2, write-side occupancy at or above which almost_full asserts.
REQ-004 Parameter AE_LEVEL, default 2, read-side occupancy at or below which almost_empty asserts.
REQ-005 w_clk  in  1  write clock.
REQ-006 r_clk  in  1  read clock, asynchronous to w_clk.
REQ-007 rst  in  1  reset, synchronous, active-high; sampled by both w_clk and r_clk.
REQ-008 w_en  in  1  write request.
REQ-009 data_in  in  WIDTH  write data.
REQ-010 r_en  in  1  read request.
REQ-011 data_out  out  WIDTH  registered read data.
REQ-012 full / almost_full  out  1 each  write-domain status, registered on w_clk.
REQ-013 empty / almost_empty  out  1 each  read-domain status, registered on r_clk.
REQ-014 wr_count  out  log2(DEPTH)+1  write-side occupancy.
REQ-015 rd_count  out  log2(DEPTH)+1  read-side occupancy.
REQ-016 overflow / underflow  out  1 each  sticky error flags (present only per REQ-034).

Function
REQ-017 Pointers SHALL be log2(DEPTH)+1 bits: binary pointer for addressing, Gray copy for crossing; wrap modulo 2*DEPTH.
REQ-018 Each Gray pointer SHALL cross into the other domain through a two-flop synchronizer; no other signal crosses domains.
REQ-019 A write is accepted on a w_clk edge when w_en=1 and full=0: mem[wptr]<=data_in, wptr increments.
REQ-020 A read is accepted on an r_clk edge when r_en=1 and empty=0: data_out<=mem[rptr], rptr increments; one r_clk latency.
REQ-021 data_out SHALL hold its value on any r_clk edge without an accepted read.
REQ-022 full SHALL assert on the same w_clk edge that accepts the DEPTH-th outstanding word (next Gray wptr equals synced Gray rptr with two MSBs inverted).
REQ-023 empty SHALL assert on the same r_clk edge that accepts the last outstanding word (next Gray rptr equals synced Gray wptr).
REQ-024 full deassertion SHALL occur within 3 w_clk edges of the freeing read; empty deassertion within 3 r_clk edges of the write; flags are pessimistic, never optimistic.
REQ-025 wr_count = wptr - synced rptr; rd_count = synced wptr - rptr; both 0..DEPTH, unsigned modulo 2*DEPTH.
REQ-026 almost_full = (wr_count >= AF_LEVEL); almost_empty = (rd_count <= AE_LEVEL); computed from next-state counts, registered.
REQ-027 w_en while full SHALL be ignored (no memory write, no pointer change); r_en while empty SHALL be ignored.
REQ-028 Simultaneous accepted write and read SHALL both complete; a write to an entry is never visible to a read on an overlapping edge before empty deasserts.
REQ-029 Wrap-around SHALL be seamless: no data loss or flag glitch when pointers pass DEPTH-1 -> 0.

Reset
REQ-030 rst=1 on a w_clk edge SHALL clear wptr, Gray wptr, w-side synchronizers, wr_count=0, full=0, almost_full=0, overflow=0.
REQ-031 rst=1 on an r_clk edge SHALL clear rptr, Gray rptr, r-side synchronizers, rd_count=0, data_out=0, empty=1, almost_empty=1, underflow=0.
REQ-032 rst SHALL be held for at least 3 edges of the slower clock; reset mid-operation discards all stored words; memory contents are not cleared.
REQ-033 While rst=1, w_en and r_en SHALL be ignored.

Configuration
REQ-034 Macro FIFO_ERR_FLAGS_EN defined: overflow sets on w_clk edge with w_en=1 and full=1, underflow sets on r_clk edge with r_en=1 and empty=1; both sticky until rst. Undefined: both ports tied 0, no flag logic.

Verification (WIDTH=8, DEPTH=16, w_clk 10 ns, r_clk 25 ns)
REQ-035 Reset, then idle -> empty=1, almost_empty=1, full=0, data_out=8'h00, counts 0.
REQ-036 Write 16 words 8'h01..8'h10, no reads -> full=1 on 16th write edge, almost_full from 14th; 17th write 8'hFF ignored, overflow=1 (macro on).
REQ-037 Then read 16 words -> data_out 8'h01..8'h10 in order, empty=1 on 16th read edge; extra r_en -> data_out holds 8'h10, underflow=1.
REQ-038 Continuous write+read of 40 words 8'h00..8'h27 -> in-order output across two pointer wraps, no full, no lost word.
REQ-039 Write 5 words, assert rst mid-stream for 3 r_clk -> empty=1, counts 0, flags clear; next write 8'hA5 then read -> data_out=8'hA5.
REQ-040 Single write 8'h3C into empty FIFO -> empty deasserts within 3 r_clk edges; rd_count=1, almost_empty=1.
